// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, FSM states,
// default latencies and op-class helpers.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bundle of the E/D-stage request signals and the HI/LO/stall responses of the
// multiply/divide controller.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, A, B, md_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, A, B, md_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl_md_alu.sv
// Combinational multiply/divide datapath: returns {hi, lo} for the given op
// (product for MULT/MULTU, {remainder, quotient} for DIV/DIVU).
module mdu_ctrl_md_alu
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res
);

  logic signed [63:0] sa, sb, sp;
  logic signed [31:0] q, r;

  always_comb begin
    res = '0;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sp  = sa * sb;
    q   = '0;
    r   = '0;
    case (op)
      MULT:  res = sp;
      MULTU: res = {32'h0, a} * {32'h0, b};
      DIV: begin
        // INT_MIN / -1 overflows; pin the architectural answer explicitly
        if (b == '0) begin
          res = '0;
        end else if (a == 32'h8000_0000 && b == '1) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          q   = $signed(a) / $signed(b);
          r   = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      DIVU: begin
        if (b != '0) res = {a % b, a / b};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV controller with HI/LO registers: results are computed at
// issue, held for a fixed busy period, then committed to HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi, res_lo;
  logic [63:0]   alu_res;

  mdu_ctrl_md_alu u_md_alu (
    .a   (A),
    .b   (B),
    .op  (op),
    .res (alu_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_muldiv(op)) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == BUSY);
  assign stall_md = md_D && (busy || (start && is_muldiv(op)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul(op)) begin
              {res_hi, res_lo} <= alu_res;
              cnt              <= CW'(MULT_LAT);
            end else if (is_div(op)) begin
              // Divide-by-zero commits the current HI/LO, which cannot change while busy
              if (B == '0) {res_hi, res_lo} <= {hi, lo};
              else         {res_hi, res_lo} <= alu_res;
              cnt <= CW'(DIV_LAT);
            end else if (op == MTHI) begin
              hi <= A;
            end else if (op == MTLO) begin
              lo <= A;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a table of single-op vectors plus hand-written
// sequences for stall timing, ignored issue while busy and mid-operation reset.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk;
  logic reset;
  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.start),
    .op       (bus.op),
    .A        (bus.A),
    .B        (bus.B),
    .md_D     (bus.md_D),
    .busy     (bus.busy),
    .stall_md (bus.stall_md),
    .hi       (bus.hi),
    .lo       (bus.lo)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int unsigned lat;
  } vec_t;

  vec_t vecs[15];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic count_busy(output int unsigned n);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int unsigned idx);
    int unsigned n;
    bus.op    = v.op;
    bus.A     = v.a;
    bus.B     = v.b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    count_busy(n);
    check($sformatf("v%0d_lat", idx), 32'(n), 32'(v.lat));
    check($sformatf("v%0d_hi", idx), bus.hi, v.exp_hi);
    check($sformatf("v%0d_lo", idx), bus.lo, v.exp_lo);
  endtask

  initial begin
    int unsigned n;

    vecs[0]  = '{MULT,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{MULTU,   32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2]  = '{DIVU,    32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 10};
    vecs[3]  = '{DIV,     32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{DIV,     32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[5]  = '{DIV,     32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[6]  = '{MTHI,    32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 0};
    vecs[7]  = '{MTLO,    32'hCAFE_F00D, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 0};
    vecs[8]  = '{DIVU,    32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 10};
    vecs[9]  = '{MULT,    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[10] = '{MULT,    32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[11] = '{MD_NONE, 32'h0000_0001, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 0};
    vecs[12] = '{4'd9,    32'h0000_0001, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 0};
    vecs[13] = '{DIVU,    32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
    vecs[14] = '{DIV,     32'h8000_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_000E, 10};

    // Reset state; stall_md follows its equation even while reset is held
    reset     = 1'b0;
    bus.md_D  = 1'b1;
    bus.start = 1'b1;
    bus.op    = MULT;
    bus.A     = '0;
    bus.B     = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_stall_issue", 32'(bus.stall_md), 32'd1);
    bus.start = 1'b0;
    #1;
    check("rst_stall_idle", 32'(bus.stall_md), 32'd0);
    bus.md_D = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 15; i++) run_vec(vecs[i], i);

    // md_D held through a MULT issue: stall in the issue cycle plus 5 busy cycles
    bus.md_D  = 1'b1;
    bus.op    = MULT;
    bus.A     = 32'h0000_0002;
    bus.B     = 32'h0000_0003;
    bus.start = 1'b1;
    #1;
    check("stall_issue", 32'(bus.stall_md), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    n = 0;
    while (bus.stall_md && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("stall_busy_cycles", 32'(n), 32'd5);
    check("stall_res_hi", bus.hi, 32'h0);
    check("stall_res_lo", bus.lo, 32'h6);

    // MTHI with md_D set does not stall
    bus.op    = MTHI;
    bus.A     = 32'hA5A5_0001;
    bus.start = 1'b1;
    #1;
    check("stall_mthi", 32'(bus.stall_md), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_D  = 1'b0;
    check("mthi_md_hi", bus.hi, 32'hA5A5_0001);
    check("mthi_md_busy", 32'(bus.busy), 32'd0);

    // MULT issued during DIV busy is ignored
    bus.op    = DIV;
    bus.A     = 32'h0000_03E8;
    bus.B     = 32'h0000_0003;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("ign_busy_c3", 32'(bus.busy), 32'd1);
    check("ign_nostall", 32'(bus.stall_md), 32'd0);
    bus.op    = MULT;
    bus.A     = 32'h0000_0003;
    bus.B     = 32'h0000_0003;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    count_busy(n);
    check("ign_total_busy", 32'(3 + n), 32'd10);
    check("ign_hi", bus.hi, 32'h0000_0001);
    check("ign_lo", bus.lo, 32'h0000_014D);

    // Reset at busy cycle 3 aborts the DIV
    bus.op    = DIV;
    bus.A     = 32'h0000_0064;
    bus.B     = 32'h0000_0007;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MD_NONE;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_vec('{DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 10}, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_LAT, default 10: busy cycles for DIV/DIVU.
REQ-003 The port list SHALL be the following, in this order:
  clk       in   1   sole clock; all state updates on rising edge.
  reset     in   1   asynchronous, active-low reset.
  start     in   1   E-stage instruction is MD-class and issues this cycle.
  op        in   4   MD operation code (package encoding).
  A         in   32  E-stage rs value.
  B         in   32  E-stage rt value.
  md_D      in   1   D-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo).
  busy      out  1   multi-cycle operation in progress.
  stall_md  out  1   stall request to the hazard unit, ORed with existing stall terms.
  hi        out  32  HI register.
  lo        out  32  LO register.

Function
REQ-004 Op encoding SHALL be MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7-15 reserved.
REQ-005 FSM states SHALL be IDLE and BUSY, plus a down-counter cnt, 4 bits minimum.
REQ-006 IDLE, start=1, op in {MULT,MULTU}: latch the 64-bit product into internal res_hi/res_lo; cnt<=MULT_LAT; ->BUSY.
REQ-007 IDLE, start=1, op in {DIV,DIVU}: latch quotient into res_lo and remainder into res_hi; cnt<=DIV_LAT; ->BUSY.
REQ-008 IDLE, start=1, op=MTHI: hi<=A on the same edge; op=MTLO: lo<=A on the same edge; state stays IDLE.
REQ-009 In BUSY, cnt SHALL decrement each cycle; when cnt==1, on that edge hi<=res_hi, lo<=res_lo and state ->IDLE.
REQ-010 busy SHALL be 1 exactly while in BUSY: LAT consecutive cycles starting the cycle after start is sampled.
REQ-011 The new hi/lo SHALL be visible in the first cycle after busy falls.
REQ-012 stall_md SHALL equal md_D && (busy || (start && op in {MULT,MULTU,DIV,DIVU})), combinational.
REQ-013 start while BUSY SHALL be ignored: no state, counter or hi/lo change.
REQ-014 start with MD_NONE or a reserved code SHALL be ignored.
REQ-015 MULT/DIV SHALL treat A,B as two's complement; MULTU/DIVU as unsigned; product is the full 64 bits, hi=upper half.
REQ-016 Signed division SHALL truncate toward zero; remainder takes the sign of the dividend.
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL give lo=0x80000000, hi=0.
REQ-018 B==0 for DIV/DIVU SHALL still run the full DIV_LAT busy period; hi/lo SHALL keep their prior values at completion.
REQ-019 No flush input; the pipeline's stall guarantees no second issue during BUSY.

Reset
REQ-020 reset low SHALL immediately force state IDLE, cnt=0, hi=0, lo=0, res_hi=res_lo=0, busy=0.
REQ-021 Reset asserted mid-BUSY SHALL abort the operation with no hi/lo update.
REQ-022 stall_md SHALL follow its equation from reset values, i.e. 0 unless md_D&&start issues a mult/div.

Structure
REQ-023 Op codes and default latencies SHALL live in the shared package/header with the existing opcode defines.
REQ-024 The datapath SHALL be flat; one optional sub-module md_alu, purely combinational: A, B, op -> 64-bit result.
REQ-025 The top-level stall SHALL be Stall | stall_md; the existing stall unit SHALL not be modified internally.

Verification
REQ-026 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-027 DIVU A=7, B=0xFFFFFFFF -> busy 10 cycles; hi=7, lo=0. DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-028 MTHI A=0x12345678 -> hi=0x12345678 next cycle; busy stays 0.
REQ-029 md_D=1 held through the whole MULT issue -> stall_md=1 in the start cycle plus 5 busy cycles, 0 after.
REQ-030 start MULT during BUSY of DIV -> ignored; only the DIV result lands, at cycle 10.
REQ-031 reset low at busy cycle 3 of DIV -> hi=lo=0, busy=0 immediately; DIV A=5, B=0 run afterwards -> 10 busy cycles, hi/lo unchanged.
